hazard_scheduler: RTL

- Central hazard controller for the 5-stage MIPS pipeline (D/E/M/W).
- Keeps its own shadow pipeline of destination register, result class and Tnew for the E, M and W stages.
- From that state it generates the stall/bubble request and the forwarding-select codes driven into the E-stage ALU operand muxes and the D-stage branch-compare muxes.
- Also sequences the multi-cycle mult/div unit: a busy counter that stalls HI/LO accesses until the result is ready.

---
 rtl/hazard_scheduler_pkg.sv | 48 ++++
 rtl/hazard_scheduler_if.sv | 30 +++
 rtl/hazard_scheduler_md_busy_counter.sv | 42 ++++
 rtl/hazard_scheduler.sv | 91 +++++++++
 4 files changed

// File: rtl/hazard_scheduler_pkg.sv
// Shared types and constants for the hazard scheduler: result classes,
// forward-select codes and the shadow pipeline entry.
package hazard_scheduler_pkg;

  typedef enum logic [1:0] {
    RES_NW  = 2'b00,
    RES_ALU = 2'b01,
    RES_DM  = 2'b10,
    RES_PC  = 2'b11
  } res_e;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [2:0] FWD_E_RF    = 3'd0;
  localparam logic [2:0] FWD_E_W_PC  = 3'd1;
  localparam logic [2:0] FWD_E_W_DM  = 3'd2;
  localparam logic [2:0] FWD_E_W_ALU = 3'd3;
  localparam logic [2:0] FWD_E_M_PC  = 3'd4;
  localparam logic [2:0] FWD_E_M_ALU = 3'd5;

  localparam logic [1:0] FWD_D_NONE  = 2'd0;
  localparam logic [1:0] FWD_D_E_PC  = 2'd1;
  localparam logic [1:0] FWD_D_M_ALU = 2'd2;
  localparam logic [1:0] FWD_D_M_PC  = 2'd3;

  typedef struct packed {
    logic [4:0] a3;
    res_e       res;
    logic [1:0] tnew;
  } shadow_t;

  localparam shadow_t BUBBLE = '{a3: 5'd0, res: RES_NW, tnew: 2'd0};

  // Cycles, counted from E entry, until the result exists in the pipeline.
  function automatic logic [1:0] tnewOf(input res_e r);
    case (r)
      RES_ALU: tnewOf = 2'd1;
      RES_DM:  tnewOf = 2'd2;
      default: tnewOf = 2'd0;
    endcase
  endfunction

  function automatic shadow_t ageEntry(input shadow_t s);
    ageEntry = s;
    if (s.tnew != 2'd0) ageEntry.tnew = s.tnew - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// D-stage instruction info into the scheduler, stall/forward controls back out.
interface hazard_scheduler_if;
  logic [4:0] A1_D;
  logic [4:0] A2_D;
  logic [1:0] Tuse_rs_D;
  logic [1:0] Tuse_rt_D;
  logic [4:0] A3_D;
  logic [1:0] Res_D;
  logic       md_start_D;
  logic       md_is_div_D;
  logic       md_use_D;
  logic       stall;
  logic       md_busy;
  logic [2:0] FRS_E;
  logic [2:0] FRT_E;
  logic [1:0] FRS_D;
  logic [1:0] FRT_D;

  modport master (
    output A1_D, A2_D, Tuse_rs_D, Tuse_rt_D, A3_D, Res_D,
           md_start_D, md_is_div_D, md_use_D,
    input  stall, md_busy, FRS_E, FRT_E, FRS_D, FRT_D
  );

  modport slave (
    input  A1_D, A2_D, Tuse_rs_D, Tuse_rt_D, A3_D, Res_D,
           md_start_D, md_is_div_D, md_use_D,
    output stall, md_busy, FRS_E, FRT_E, FRS_D, FRT_D
  );
endinterface

// File: rtl/hazard_scheduler_md_busy_counter.sv
// Busy counter for the multi-cycle mult/div unit; busy covers the start
// sitting in E as well as the loaded count.
module md_busy_counter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic isDiv_i,
  output logic busy_o
);

  localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pending_q;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i)
      cnt_d = isDiv_i ? DivLoad : MultLoad;
    else if (cnt_q != '0)
      cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= start_i;
    end
  end

  assign busy_o = (cnt_q != '0) | pending_q;

endmodule

// File: rtl/hazard_scheduler.sv
// Central hazard controller: shadow E/M/W pipeline of destination, class and
// Tnew, producing the stall request and the E/D-stage forward selects.
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic               clk,
  input logic               rst_n,
  hazard_scheduler_if.slave hz
);

  shadow_t    eEntry_q, mEntry_q, wEntry_q, eEntry_d;
  logic [4:0] rsE_q, rtE_q, rsE_d, rtE_d;
  logic       regStall, stall, mdBusy, mdStart;
  res_e       resD;

  function automatic logic srcHazard(input logic [4:0] idx, input logic [1:0] tuse,
                                     input shadow_t e, input shadow_t m);
    srcHazard = (idx != 5'd0) && (tuse != TUSE_NONE) &&
                (((e.a3 == idx) && (e.tnew > tuse)) || ((m.a3 == idx) && (m.tnew > tuse)));
  endfunction

  // An M-stage load has Tnew 1 here, so it falls through to W.
  function automatic logic [2:0] fwdE(input logic [4:0] idx, input shadow_t m, input shadow_t w);
    fwdE = FWD_E_RF;
    if (idx != 5'd0) begin
      if (m.a3 == idx && m.tnew == 2'd0 && m.res == RES_ALU)      fwdE = FWD_E_M_ALU;
      else if (m.a3 == idx && m.tnew == 2'd0 && m.res == RES_PC)  fwdE = FWD_E_M_PC;
      else if (w.a3 == idx && w.tnew == 2'd0 && w.res == RES_ALU) fwdE = FWD_E_W_ALU;
      else if (w.a3 == idx && w.tnew == 2'd0 && w.res == RES_DM)  fwdE = FWD_E_W_DM;
      else if (w.a3 == idx && w.tnew == 2'd0 && w.res == RES_PC)  fwdE = FWD_E_W_PC;
    end
  endfunction

  function automatic logic [1:0] fwdD(input logic [4:0] idx, input shadow_t e, input shadow_t m);
    fwdD = FWD_D_NONE;
    if (idx != 5'd0) begin
      if (e.a3 == idx && e.res == RES_PC)       fwdD = FWD_D_E_PC;
      else if (m.a3 == idx && m.res == RES_ALU) fwdD = FWD_D_M_ALU;
      else if (m.a3 == idx && m.res == RES_PC)  fwdD = FWD_D_M_PC;
    end
  endfunction

  always_comb begin
    resD     = res_e'(hz.Res_D);
    regStall = srcHazard(hz.A1_D, hz.Tuse_rs_D, eEntry_q, mEntry_q) |
               srcHazard(hz.A2_D, hz.Tuse_rt_D, eEntry_q, mEntry_q);
    stall    = regStall | (hz.md_use_D & mdBusy);
    mdStart  = hz.md_start_D & ~stall;
    eEntry_d = stall ? BUBBLE : '{a3: hz.A3_D, res: resD, tnew: tnewOf(resD)};
    rsE_d    = stall ? 5'd0 : hz.A1_D;
    rtE_d    = stall ? 5'd0 : hz.A2_D;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eEntry_q <= BUBBLE;
      mEntry_q <= BUBBLE;
      wEntry_q <= BUBBLE;
      rsE_q    <= 5'd0;
      rtE_q    <= 5'd0;
    end else begin
      eEntry_q <= eEntry_d;
      mEntry_q <= ageEntry(eEntry_q);
      wEntry_q <= ageEntry(mEntry_q);
      rsE_q    <= rsE_d;
      rtE_q    <= rtE_d;
    end
  end

  md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdCounter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(mdStart),
    .isDiv_i(hz.md_is_div_D),
    .busy_o (mdBusy)
  );

  assign hz.stall   = stall;
  assign hz.md_busy = mdBusy;
  assign hz.FRS_E   = fwdE(rsE_q, mEntry_q, wEntry_q);
  assign hz.FRT_E   = fwdE(rtE_q, mEntry_q, wEntry_q);
  assign hz.FRS_D   = fwdD(hz.A1_D, eEntry_q, mEntry_q);
  assign hz.FRT_D   = fwdD(hz.A2_D, eEntry_q, mEntry_q);

endmodule
